result_serializer: RTL and testbench

RESULT_SERIALIZER -- requirements
Module: result_serializer

---
 rtl/result_pkg.sv | 18 +
 rtl/result_checksum.sv | 36 +++
 rtl/result_serializer.sv | 151 +++++++++++++++
 tb/tb_result_serializer.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/result_pkg.sv
// Shared types and constants for the result serializer.
// Optional feature macro: RESULT_CHECKSUM_EN adds the CSUM state.
package result_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int MAX_WORDS_DEF  = 10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
`ifdef RESULT_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_FINISH
    } state_e;

endpackage

// File: rtl/result_checksum.sv
// Running XOR of every payload byte accepted during one dump.
// Only instantiated when RESULT_CHECKSUM_EN is defined.
module result_checksum (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] byte_i,
    output logic [7:0] csum_o
);

    logic [7:0] acc_q;
    logic [7:0] acc_d;

    // Clear at the start of a dump, fold in each accepted byte.
    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = 8'h00;
        end else if (en_i) begin
            acc_d = acc_q ^ byte_i;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_q <= 8'h00;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign csum_o = acc_q;

endmodule

// File: rtl/result_serializer.sv
// Dumps up to MAX_WORDS 32-bit result registers as a byte stream with a
// valid/ready handshake, then pulses done (and clear_data if anything was sent).
// Optional feature macro: RESULT_CHECKSUM_EN appends an XOR checksum byte.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | read register word_idx into the shift register
// SEND   | present 4 bytes of the current word
// CSUM   | present checksum byte (RESULT_CHECKSUM_EN only)
// FINISH | one-cycle done / clear_data pulse
module result_serializer
    import result_pkg::*;
#(
    parameter int MAX_WORDS = MAX_WORDS_DEF,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [3:0]  num_words,
    output logic [3:0]  out_sel,
    input  logic [31:0] out_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        clear_data,
    output logic        busy,
    output logic        done
);

    // num_words is only 4 bits wide, so the clamp never needs more than 15.
    localparam logic [3:0] MAX_W4 = (MAX_WORDS > 15) ? 4'd15 : 4'(MAX_WORDS);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  word_idx_q, word_idx_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] shift_q, shift_d;

    logic [3:0]  cnt_lim;
    logic [7:0]  cur_byte;
    logic        more_words;

    assign cnt_lim    = (num_words > MAX_W4) ? MAX_W4 : num_words;
    assign cur_byte   = MSB_FIRST ? shift_q[31:24] : shift_q[7:0];
    assign more_words = ({1'b0, word_idx_q} + 5'd1) < {1'b0, cnt_q};

`ifdef RESULT_CHECKSUM_EN
    logic [7:0] csum;
    logic       csum_clr;
    logic       csum_en;

    assign csum_clr = (state_q == ST_IDLE) && start;
    assign csum_en  = (state_q == ST_SEND) && tx_ready;

    result_checksum u_checksum (
        .clk    (clk),
        .n_rst  (n_rst),
        .clr_i  (csum_clr),
        .en_i   (csum_en),
        .byte_i (cur_byte),
        .csum_o (csum)
    );
`endif

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        word_idx_d = word_idx_q;
        byte_idx_d = byte_idx_q;
        shift_d    = shift_q;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_d      = cnt_lim;
                    word_idx_d = 4'd0;
                    state_d    = (cnt_lim == 4'd0) ? ST_FINISH : ST_LOAD;
                end
            end
            ST_LOAD: begin
                shift_d    = out_data;
                byte_idx_d = 2'd0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                tx_data  = cur_byte;
                if (tx_ready) begin
                    shift_d    = MSB_FIRST ? (shift_q << 8) : (shift_q >> 8);
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == LAST_BYTE) begin
                        if (more_words) begin
                            word_idx_d = word_idx_q + 4'd1;
                            state_d    = ST_LOAD;
                        end else begin
`ifdef RESULT_CHECKSUM_EN
                            state_d = ST_CSUM;
`else
                            state_d = ST_FINISH;
`endif
                        end
                    end
                end
            end
`ifdef RESULT_CHECKSUM_EN
            ST_CSUM: begin
                tx_valid = 1'b1;
                tx_data  = csum;
                if (tx_ready) begin
                    state_d = ST_FINISH;
                end
            end
`endif
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 4'd0;
            word_idx_q <= 4'd0;
            byte_idx_q <= 2'd0;
            shift_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            word_idx_q <= word_idx_d;
            byte_idx_q <= byte_idx_d;
            shift_q    <= shift_d;
        end
    end

    // Status outputs decoded from the registered state; a reset mid-dump
    // lands in IDLE so neither pulse can fire.
    assign busy       = (state_q != ST_IDLE);
    assign done       = (state_q == ST_FINISH);
    assign clear_data = (state_q == ST_FINISH) && (cnt_q != 4'd0);
    assign out_sel    = (state_q == ST_IDLE) ? 4'd0 : word_idx_q;

endmodule

// File: tb/tb_result_serializer.sv
// Scoreboard bench for result_serializer: directed dumps push expected bytes,
// a negedge monitor pops and compares every accepted byte.
module tb_result_serializer;

`ifdef RESULT_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic        clk = 1'b0;
    logic        n_rst;
    logic        start;
    logic [3:0]  num_words;
    logic [3:0]  out_sel;
    logic [31:0] out_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        clear_data;
    logic        busy;
    logic        done;

    logic [31:0] regs [0:15];
    assign out_data = regs[out_sel];

    result_serializer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .num_words  (num_words),
        .out_sel    (out_sel),
        .out_data   (out_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .clear_data (clear_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q [$];
    logic [7:0] csum_acc;
    int         bytes_seen = 0;
    int         done_cnt = 0;
    int         clr_cnt = 0;
    int         max_sel = 0;
    logic       stall_q = 1'b0;
    logic [7:0] prev_data = 8'h00;
    bit         rnd_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Downstream ready: either held high or randomly toggled.
    always @(posedge clk) begin
        #1;
        tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor: stability while stalled, byte scoreboard, pulse counting.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!n_rst) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("stall_valid_held", 32'(tx_valid), 32'd1);
                check("stall_data_held", 32'(tx_data), 32'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %02h expected none", tx_data);
                end else begin
                    e = exp_q.pop_front();
                    check("byte", 32'(tx_data), 32'(e));
                end
                bytes_seen++;
            end
            if (done) done_cnt++;
            if (clear_data) clr_cnt++;
            if (int'(out_sel) > max_sel) max_sel = int'(out_sel);
            stall_q   = tx_valid && !tx_ready;
            prev_data = tx_data;
        end
    end

    task automatic push_word(input logic [31:0] w);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[31 - 8*i -: 8];
            exp_q.push_back(b);
            csum_acc = csum_acc ^ b;
        end
    endtask

    task automatic push_csum();
`ifdef RESULT_CHECKSUM_EN
        exp_q.push_back(csum_acc);
`endif
    endtask

    task automatic start_dump(input logic [3:0] n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        num_words = n;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk);
            if (done) break;
        end
        check({name, "_done_seen"}, 32'(k < budget), 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int base, first_k, done_k, clr_k, d0, c0;
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int base, first_k, done_k, clr_k, d0, c0;
        n_rst     = 1'b0;
        start     = 1'b0;
        num_words = 4'd0;
        for (int i = 0; i < 16; i++) regs[i] = 32'hBAD0BAD0;
        #23;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_tx_valid", 32'(tx_valid), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_clear", 32'(clear_data), 32'd0);
        check("rst_out_sel", 32'(out_sel), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Two words, ready high: exact cycle timing.
        regs[0] = 32'hDEADBEEF;
        regs[1] = 32'h01020304;
        csum_acc = 8'h00;
        push_word(regs[0]);
        push_word(regs[1]);
        push_csum();
        base = bytes_seen;
        first_k = -1; done_k = -1; clr_k = -1;
        start_dump(4'd2);
        for (int k = 1; k < 40; k++) begin
            @(negedge clk);
            if (tx_valid && first_k < 0) first_k = k;
            if (clear_data) clr_k = k;
            if (done) begin
                done_k = k;
                break;
            end
        end
        check("t1_first_valid_cycle", 32'(first_k), 32'd2);
        check("t1_done_cycle", 32'(done_k), 32'(11 + CS));
        check("t1_clear_cycle", 32'(clr_k), 32'(11 + CS));
        @(posedge clk);
        #1;
        check("t1_byte_count", 32'(bytes_seen - base), 32'(8 + CS));
        check("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // Three words, random backpressure.
        regs[0] = 32'hA1B2C3D4;
        regs[1] = 32'h55AA0FF0;
        regs[2] = 32'h12345678;
        csum_acc = 8'h00;
        for (int i = 0; i < 3; i++) push_word(regs[i]);
        push_csum();
        base = bytes_seen;
        rnd_ready = 1'b1;
        start_dump(4'd3);
        wait_done("t2", 400);
        rnd_ready = 1'b0;
        check("t2_byte_count", 32'(bytes_seen - base), 32'(12 + CS));
        check("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero words: done one cycle after start, nothing sent or cleared.
        base = bytes_seen;
        start_dump(4'd0);
        @(negedge clk);
        check("t3_done_cycle1", 32'(done), 32'd1);
        check("t3_clear_cycle1", 32'(clear_data), 32'd0);
        check("t3_no_valid", 32'(tx_valid), 32'd0);
        @(negedge clk);
        check("t3_done_one_cycle", 32'(done), 32'd0);
        check("t3_byte_count", 32'(bytes_seen - base), 32'd0);

        // Fifteen requested, clamped to ten.
        for (int i = 0; i < 10; i++) regs[i] = {8'(i), 8'(8'hA0 + i), 8'(8'h50 + i), 8'(8'hF0 - i)};
        csum_acc = 8'h00;
        for (int i = 0; i < 10; i++) push_word(regs[i]);
        push_csum();
        base = bytes_seen;
        max_sel = 0;
        start_dump(4'd15);
        wait_done("t4", 400);
        check("t4_byte_count", 32'(bytes_seen - base), 32'(40 + CS));
        check("t4_max_out_sel", 32'(max_sel), 32'd9);
        check("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset after five accepted bytes.
        regs[0] = 32'hCAFEF00D;
        regs[1] = 32'h0BADC0DE;
        csum_acc = 8'h00;
        push_word(regs[0]);
        push_word(regs[1]);
        push_csum();
        base = bytes_seen;
        d0 = done_cnt;
        c0 = clr_cnt;
        start_dump(4'd2);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (bytes_seen - base >= 5) break;
        end
        check("t5_five_bytes", 32'(bytes_seen - base), 32'd5);
        @(posedge clk);
        #1;
        check("t5_valid_before_rst", 32'(tx_valid), 32'd1);
        n_rst = 1'b0;
        #1;
        check("t5_valid_falls", 32'(tx_valid), 32'd0);
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_done_rst", 32'(done), 32'd0);
        check("t5_clear_rst", 32'(clear_data), 32'd0);
        exp_q.delete();
        @(posedge clk);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        check("t5_no_done_pulse", 32'(done_cnt), 32'(d0));
        check("t5_no_clear_pulse", 32'(clr_cnt), 32'(c0));
        regs[0] = 32'h0F1E2D3C;
        csum_acc = 8'h00;
        push_word(regs[0]);
        push_csum();
        base = bytes_seen;
        start_dump(4'd1);
        wait_done("t5_after", 100);
        check("t5_after_bytes", 32'(bytes_seen - base), 32'(4 + CS));
        check("t5_after_queue_empty", 32'(exp_q.size()), 32'd0);
        check("t5_after_clear", 32'(clr_cnt), 32'(c0 + 1));

        // Single word with checksum byte when enabled (11^22^33^44 = 44).
        regs[0] = 32'h11223344;
        csum_acc = 8'h00;
        push_word(regs[0]);
`ifdef RESULT_CHECKSUM_EN
        exp_q.push_back(8'h44);
`endif
        base = bytes_seen;
        start_dump(4'd1);
        wait_done("t6", 100);
        check("t6_byte_count", 32'(bytes_seen - base), 32'(4 + CS));
        check("t6_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
